// File: rtl/calc_pkg.sv
// Shared types and constants for keypad operand entry.
package calc_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    ERR   = 2'd3
  } entry_state_t;

  localparam logic       DISP_DEC      = 1'b0;
  localparam logic       DISP_HEX      = 1'b1;
  localparam logic [3:0] DEC_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/digit_entry_if.sv
// Keypad-side strobes and committed operand / echo outputs.
interface digit_entry_if #(
  parameter int WIDTH = 6
);
  logic             display_mode;
  logic             digit_valid;
  logic [3:0]       digit_value;
  logic             neg_toggle;
  logic             enter;
  logic             clear;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic [3:0]       digit0;
  logic [3:0]       digit1;
  logic             is_negative;
  logic             error;

  modport master (
    output display_mode, digit_valid, digit_value,
    output neg_toggle, enter, clear,
    input  data, data_valid, digit0, digit1,
    input  is_negative, error
  );

  modport slave (
    input  display_mode, digit_valid, digit_value,
    input  neg_toggle, enter, clear,
    output data, data_valid, digit0, digit1,
    output is_negative, error
  );
endinterface

// File: rtl/entry_magnitude.sv
// Two-digit magnitude (decimal or hex) and signed range check.
module entry_magnitude
  import calc_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       mode,
  input  logic       neg,
  output logic [7:0] magnitude,
  output logic       in_range
);
  localparam logic [8:0] POS_LIM = 9'((1 << (WIDTH-1)) - 1);
  localparam logic [8:0] NEG_LIM = 9'(1 << (WIDTH-1));

  always_comb begin
    magnitude = {digit1, digit0};
    if (mode == DISP_DEC)
      magnitude = 8'(digit1) * 8'd10 + 8'(digit0);
  end

  assign in_range = {1'b0, magnitude} <= (neg ? NEG_LIM : POS_LIM);
endmodule

// File: rtl/digit_entry.sv
// Keypad digit assembly into a signed operand with range check.
// Build option DIGIT_ENTRY_SATURATE_EN clamps out-of-range commits.
module digit_entry
  import calc_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input logic         clk,
  input logic         reset,
  digit_entry_if.slave bus
);
  entry_state_t st;
  logic         mode_q;
  logic [7:0]   magnitude;
  logic         in_range;
  logic [7:0]   commit;
  logic         eff_mode;
  logic         illegal;

  entry_magnitude #(.WIDTH(WIDTH)) u_mag (
    .digit0    (bus.digit0),
    .digit1    (bus.digit1),
    .mode      (mode_q),
    .neg       (bus.is_negative),
    .magnitude (magnitude),
    .in_range  (in_range)
  );

  assign commit = bus.is_negative ? 8'd0 - magnitude
                                  : magnitude;

  // the mode is only taken from the keypad on the first digit
  assign eff_mode = (st == EMPTY) ? bus.display_mode : mode_q;
  assign illegal  = (eff_mode == DISP_DEC) &&
                    (bus.digit_value > DEC_MAX_DIGIT);

`ifdef DIGIT_ENTRY_SATURATE_EN
  localparam logic [WIDTH-1:0] POS_SAT =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_SAT =
    {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= EMPTY;
      mode_q          <= DISP_DEC;
      bus.data        <= '0;
      bus.data_valid  <= 1'b0;
      bus.digit0      <= 4'd0;
      bus.digit1      <= 4'd0;
      bus.is_negative <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      if (bus.clear) begin
        st              <= EMPTY;
        bus.digit0      <= 4'd0;
        bus.digit1      <= 4'd0;
        bus.is_negative <= 1'b0;
        bus.error       <= 1'b0;
      end else if (bus.enter) begin
        if (st != ERR) begin
          if (in_range) begin
            bus.data        <= WIDTH'(commit);
            bus.data_valid  <= 1'b1;
            st              <= EMPTY;
            bus.digit0      <= 4'd0;
            bus.digit1      <= 4'd0;
            bus.is_negative <= 1'b0;
          end else begin
`ifdef DIGIT_ENTRY_SATURATE_EN
            bus.data        <= bus.is_negative ? NEG_SAT
                                               : POS_SAT;
            bus.data_valid  <= 1'b1;
            st              <= EMPTY;
            bus.digit0      <= 4'd0;
            bus.digit1      <= 4'd0;
            bus.is_negative <= 1'b0;
`else
            st        <= ERR;
            bus.error <= 1'b1;
`endif
          end
        end
      end else if (st != ERR) begin
        if (bus.neg_toggle)
          bus.is_negative <= ~bus.is_negative;
        if (bus.digit_valid) begin
          if (illegal || st == TWO) begin
            st        <= ERR;
            bus.error <= 1'b1;
          end else if (st == EMPTY) begin
            st         <= ONE;
            mode_q     <= bus.display_mode;
            bus.digit0 <= bus.digit_value;
          end else begin
            st         <= TWO;
            bus.digit1 <= bus.digit0;
            bus.digit0 <= bus.digit_value;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_digit_entry.sv
// Directed vector table plus random run against a reference model.
module tb_digit_entry;
  localparam int W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  digit_entry_if #(.WIDTH(W)) bus ();
  digit_entry #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       clr, ent, dv;
    logic [3:0] val;
    logic       ng, md;
    logic [5:0] e_data;
    logic       e_dv;
    logic [3:0] e_d0, e_d1;
    logic       e_neg, e_err;
  } vec_t;

  vec_t vecs[$];

  // reference model: digits as a list, sign, mode, error flag
  int   m_q[$];
  bit   m_neg, m_mode, m_err, m_valid;
  int   m_data;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic v(logic c, logic e, logic d, int val,
                   logic n, logic md, int ed, logic edv,
                   int e0, int e1, logic en, logic er);
    vec_t x;
    x.clr = c; x.ent = e; x.dv = d; x.val = 4'(val);
    x.ng = n; x.md = md; x.e_data = 6'(ed); x.e_dv = edv;
    x.e_d0 = 4'(e0); x.e_d1 = 4'(e1);
    x.e_neg = en; x.e_err = er;
    vecs.push_back(x);
  endtask

  task automatic drive(logic r, logic c, logic e, logic d,
                       logic [3:0] val, logic n, logic md);
    reset = r;
    bus.clear = c;
    bus.enter = e;
    bus.digit_valid = d;
    bus.digit_value = val;
    bus.neg_toggle = n;
    bus.display_mode = md;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_mag();
    if (m_q.size() == 0) return 0;
    if (m_q.size() == 1) return m_q[0];
    return m_q[0] * (m_mode ? 16 : 10) + m_q[1];
  endfunction

  task automatic model_step(bit r, bit c, bit e, bit d,
                            int val, bit n, bit md);
    int mag, lim;
    bit md_eff;
    m_valid = 0;
    if (r) begin
      m_q.delete(); m_neg = 0; m_mode = 0;
      m_err = 0; m_data = 0;
    end else if (c) begin
      m_q.delete(); m_neg = 0; m_err = 0;
    end else if (e) begin
      if (!m_err) begin
        mag = model_mag();
        lim = m_neg ? 2**(W-1) : 2**(W-1) - 1;
        if (mag <= lim) begin
          m_data = m_neg ? -mag : mag;
          m_valid = 1; m_q.delete(); m_neg = 0;
        end else begin
`ifdef DIGIT_ENTRY_SATURATE_EN
          m_data = m_neg ? -(2**(W-1)) : 2**(W-1) - 1;
          m_valid = 1; m_q.delete(); m_neg = 0;
`else
          m_err = 1;
`endif
        end
      end
    end else if (!m_err) begin
      if (n) m_neg = !m_neg;
      if (d) begin
        md_eff = (m_q.size() == 0) ? md : m_mode;
        if ((!md_eff && val > 9) || m_q.size() == 2)
          m_err = 1;
        else begin
          if (m_q.size() == 0) m_mode = md;
          m_q.push_back(val);
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    int e0, e1;
    logic [5:0] ed;
    ed = m_data[5:0];
    e0 = m_q.size() > 0 ? m_q[m_q.size()-1] : 0;
    e1 = m_q.size() == 2 ? m_q[0] : 0;
    chk({tag, ".data"}, int'(bus.data), int'(ed));
    chk({tag, ".valid"}, int'(bus.data_valid), int'(m_valid));
    chk({tag, ".d0"}, int'(bus.digit0), e0);
    chk({tag, ".d1"}, int'(bus.digit1), e1);
    chk({tag, ".neg"}, int'(bus.is_negative), int'(m_neg));
    chk({tag, ".err"}, int'(bus.error), int'(m_err));
  endtask

  initial begin
    int held;
    bit r, c, e, d, n, md;
    int val;

    // c e d val n md | data dv d0 d1 neg err
    v(0,0,1, 2,0,0,  0,0, 2,0,0,0);
    v(0,0,1, 5,0,0,  0,0, 5,2,0,0);
    v(0,0,0, 0,1,0,  0,0, 5,2,1,0);
    v(0,1,0, 0,0,0, 39,1, 0,0,0,0);
    v(0,0,0, 0,0,0, 39,0, 0,0,0,0);
    v(0,0,1, 3,0,0, 39,0, 3,0,0,0);
    v(0,0,1, 3,0,0, 39,0, 3,3,0,0);
    v(0,1,0, 0,0,0, 39,0, 3,3,0,1);
    v(1,0,0, 0,0,0, 39,0, 0,0,0,0);
    v(0,0,1, 2,0,1, 39,0, 2,0,0,0);
    v(0,0,1, 0,0,0, 39,0, 0,2,0,0);
    v(0,0,0, 0,1,0, 39,0, 0,2,1,0);
    v(0,1,0, 0,0,0, 32,1, 0,0,0,0);
    v(0,0,1, 2,0,1, 32,0, 2,0,0,0);
    v(0,0,1, 0,0,1, 32,0, 0,2,0,0);
`ifdef DIGIT_ENTRY_SATURATE_EN
    held = 31;
    v(0,1,0, 0,0,0, 31,1, 0,0,0,0);
`else
    held = 32;
    v(0,1,0, 0,0,0, 32,0, 0,2,0,1);
`endif
    v(1,0,0, 0,0,0, held,0, 0,0,0,0);
    v(0,0,1,10,0,0, held,0, 0,0,0,1);
    v(0,0,1, 1,0,0, held,0, 0,0,0,1);
    v(0,1,0, 0,0,0, held,0, 0,0,0,1);
    v(1,0,0, 0,0,0, held,0, 0,0,0,0);
    v(0,0,1, 1,0,0, held,0, 1,0,0,0);
    v(0,0,1, 2,0,0, held,0, 2,1,0,0);
    v(0,0,1, 3,0,0, held,0, 2,1,0,1);
    v(0,1,1, 4,1,0, held,0, 2,1,0,1);
    v(1,0,0, 0,0,0, held,0, 0,0,0,0);
    v(0,0,1, 7,0,0, held,0, 7,0,0,0);
    v(0,1,1, 4,1,0,  7,1, 0,0,0,0);
    v(0,0,1, 5,0,0,  7,0, 5,0,0,0);
    v(1,1,0, 0,0,0,  7,0, 0,0,0,0);
    v(0,1,0, 0,0,0,  0,1, 0,0,0,0);
    v(0,1,0, 0,0,0,  0,1, 0,0,0,0);
    v(0,0,1, 9,1,0,  0,0, 9,0,1,0);
    v(0,0,1, 2,0,1,  0,0, 2,9,1,0);
    v(0,1,0, 0,0,0,  0,0, 2,9,1,1);

    drive(1, 0,0,0, 4'd0, 0, 0);
    drive(1, 0,0,0, 4'd0, 0, 0);
    chk("rst.data", int'(bus.data), 0);
    chk("rst.valid", int'(bus.data_valid), 0);
    chk("rst.err", int'(bus.error), 0);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(0, vecs[i].clr, vecs[i].ent, vecs[i].dv,
            vecs[i].val, vecs[i].ng, vecs[i].md);
      chk({t, ".data"}, int'(bus.data), int'(vecs[i].e_data));
      chk({t, ".valid"}, int'(bus.data_valid),
          int'(vecs[i].e_dv));
      chk({t, ".d0"}, int'(bus.digit0), int'(vecs[i].e_d0));
      chk({t, ".d1"}, int'(bus.digit1), int'(vecs[i].e_d1));
      chk({t, ".neg"}, int'(bus.is_negative),
          int'(vecs[i].e_neg));
      chk({t, ".err"}, int'(bus.error), int'(vecs[i].e_err));
    end

    // reset while in ONE with sign set, then enter commits 0
    drive(0, 1,0,0, 4'd0, 0, 0);
    drive(0, 0,0,1, 4'd4, 1, 0);
    drive(0, 0,1,0, 4'd0, 0, 0);
    drive(0, 0,0,1, 4'd6, 1, 0);
    chk("pre.neg", int'(bus.is_negative), 1);
    chk("pre.data", int'(bus.data), 60);
    drive(1, 0,0,0, 4'd0, 0, 0);
    chk("rstone.data", int'(bus.data), 0);
    chk("rstone.d0", int'(bus.digit0), 0);
    chk("rstone.neg", int'(bus.is_negative), 0);
    chk("rstone.valid", int'(bus.data_valid), 0);
    drive(0, 0,1,0, 4'd0, 0, 0);
    chk("rstone.ent.valid", int'(bus.data_valid), 1);
    chk("rstone.ent.data", int'(bus.data), 0);

    model_step(1, 0,0,0, 0, 0, 0);
    drive(1, 0,0,0, 4'd0, 0, 0);
    check_model("rnd.rst");
    md = 0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 6) == 0);
      d = ($urandom_range(0, 9) < 4);
      n = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) md = ~md;
      val = ($urandom_range(0, 3) == 0) ?
            $urandom_range(0, 15) : $urandom_range(0, 9);
      model_step(r, c, e, d, val, n, md);
      drive(r, c, e, d, 4'(val), n, md);
      check_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
